matrix_multiplier_axil_slave: RTL and testbench
===============================================

# matrix_multiplier_axil_slave

AXI4-Lite slave register bank exposing control, status and configuration of the matrix multiplier core on the S00_AXI port. It is the responder driven by the AXI VIP master in the block design. It decodes single-beat reads and writes into eight 32-bit registers, generates a one-cycle start pulse to the core, and latches the core's completion into a sticky status bit with interrupt output.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width; 8 words, decoded by addr[4:2].
- VERSION, 32'h0001_0000: value returned by the VERSION register.

Ports:
- s00_axi_aclk, in, 1: sole clock.
- s00_axi_areset, in, 1: reset, synchronous, active-high.
- s00_axi_awaddr / awprot / awvalid / awready: in / in / in / out; widths ADDR_WIDTH / 3 / 1 / 1. awprot is ignored.
- s00_axi_wdata / wstrb / wvalid / wready: in / in / in / out; widths 32 / 4 / 1 / 1.
- s00_axi_bresp / bvalid / bready: out / out / in; widths 2 / 1 / 1.
- s00_axi_araddr / arprot / arvalid / arready: in / in / in / out; widths ADDR_WIDTH / 3 / 1 / 1.
- s00_axi_rdata / rresp / rvalid / rready: out / out / out / in; widths 32 / 2 / 1 / 1.
- busy_i, in, 1: core busy.
- done_i, in, 1: one-cycle completion pulse from the core.
- start_o, out, 1: one-cycle start pulse to the core.
- dim_o / a_base_o / b_base_o / c_base_o, out, 32 each: configuration registers.
- irq_o, out, 1: interrupt, equal to DONE & IRQ_EN.

## Operation
Register map:
- 0x00 CTRL: bit0 START writes 1 to pulse start_o and always reads 0; bit1 IRQ_EN is RW; other bits read 0.
- 0x04 STATUS: bit0 BUSY is RO and mirrors busy_i; bit1 DONE is sticky and W1C.
- 0x08 DIM, 0x0C A_BASE, 0x10 B_BASE, 0x14 C_BASE, 0x18 SCRATCH: RW, reset to 0.
- 0x1C VERSION: RO, returns the VERSION parameter.

Write path. FSM states are W_IDLE and W_RESP.
- W_IDLE: awready is high until AW is captured; wready is high until W is captured. AW and W may arrive in either order, simultaneously, or separated by any gap.
- When both AW and W are captured, the register commit and bvalid=1 occur on the next edge, and the FSM moves to W_RESP.
- W_RESP: awready=wready=0. bvalid is held until bready; the handshake returns the FSM to W_IDLE.
- Only one write is outstanding at a time.
- wstrb merges bytes into the register. Strobed bits of RO registers are ignored.
- bresp is always OKAY (2'b00).

START:
- start_o pulses for exactly one cycle at the commit edge when wstrb[0] & wdata[0] are set and busy_i=0.
- If busy_i=1, the START write is ignored (no pulse) but still responds OKAY.

DONE:
- DONE is set by done_i.
- Writing wdata[1]=1 with wstrb[0] clears DONE.
- If done_i and the clear occur in the same cycle, set wins.

Read path. FSM states are R_IDLE and R_DATA.
- R_IDLE: arready=1.
- The AR handshake registers rdata and asserts rvalid on the next edge.
- R_DATA: arready=0. rdata is held stable until rready; the handshake returns the FSM to R_IDLE.
- rresp is always OKAY.

Read/write interaction:
- Read and write paths run concurrently.
- A read sampling the same edge as a write commit returns the pre-write value.

## Timing
- Reset values: awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, start_o=0, irq_o=0. All registers are 0 except VERSION.
- Write latency: the commit and bvalid occur 1 edge after the later of the AW/W handshakes. The minimum write is 2 cycles with bready=1.
- Read latency: rvalid rises 1 edge after the AR handshake. Back-to-back reads proceed at one per 2 cycles.
- irq_o is registered and follows DONE/IRQ_EN with 0 extra cycles after the register update.
- Reset mid-transaction: any captured AW/W/AR is dropped, bvalid/rvalid deassert on the reset edge, and no commit occurs.

## Structure
- The package matrix_multiplier_regs_pkg holds:
  - word-offset localparams (CTRL..VERSION);
  - bit indices (START, IRQ_EN, BUSY, DONE);
  - register reset values;
  - the wstrb-merge function;
  - the write and read FSM state enums.
- No sub-module: the write FSM, read FSM and register file live in one module.

## Test plan
- Sequential write/read: write 0x1..0x5 to 0x08..0x18, then read back. Each read returns the value written; all BRESP/RRESP are OKAY; VERSION reads 0x0001_0000.
- Order and strobe: W presented 3 cycles before AW, with wstrb=4'b0010 and wdata=0xAABBCCDD to SCRATCH. SCRATCH then reads 0x0000CC00.
- Backpressure: hold bready=0 for 5 cycles. bvalid stays 1; awready=wready=0; a second queued write is accepted only after the B handshake.
- START: write CTRL=0x1 with busy_i=0. start_o is high for exactly 1 cycle and CTRL reads 0x0. Repeat with busy_i=1: start_o stays 0.
- DONE/IRQ:
  - Write CTRL=0x2, then pulse done_i. irq_o=1.
  - Issue a W1C write to STATUS (0x2) in the same cycle as another done_i. DONE stays 1.
  - Issue a later W1C. irq_o=0.
- Reset mid-write: assert s00_axi_areset while bvalid=1. bvalid drops on that edge, DIM reads 0, and VERSION is intact.

Source files
------------

// File: rtl/matrix_multiplier_regs_pkg.sv
// Register map, bit positions, reset values, the byte-strobe merge helper and
// the read/write state encodings for the matrix multiplier AXI4-Lite slave.
package matrix_multiplier_regs_pkg;

    // Word offsets (byte address bits [4:2])
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_DIM     = 3'd2;
    localparam logic [2:0] REG_A_BASE  = 3'd3;
    localparam logic [2:0] REG_B_BASE  = 3'd4;
    localparam logic [2:0] REG_C_BASE  = 3'd5;
    localparam logic [2:0] REG_SCRATCH = 3'd6;
    localparam logic [2:0] REG_VERSION = 3'd7;

    // Bit indices inside CTRL and STATUS
    localparam int BIT_START  = 0;
    localparam int BIT_IRQ_EN = 1;
    localparam int BIT_BUSY   = 0;
    localparam int BIT_DONE   = 1;

    // Reset values
    localparam logic [31:0] RST_CFG = 32'h0000_0000;
    localparam logic        RST_BIT = 1'b0;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Replace only the bytes whose strobe is set
    function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return result;
    endfunction

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/matrix_multiplier_axil_slave.sv
// AXI4-Lite register bank for the matrix multiplier core: configuration
// registers, a one-cycle start pulse, sticky DONE status and an interrupt.
// Handshake rule on every channel: a transfer happens on the rising edge where
// both VALID and READY are high; VALID, once raised, holds its payload until then.
module matrix_multiplier_axil_slave
    import matrix_multiplier_regs_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] VERSION            = 32'h0001_0000
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic                            busy_i,
    input  logic                            done_i,
    output logic                            start_o,
    output logic [31:0]                     dim_o,
    output logic [31:0]                     a_base_o,
    output logic [31:0]                     b_base_o,
    output logic [31:0]                     c_base_o,
    output logic                            irq_o
);

    w_state_t    r_wstate;
    r_state_t    r_rstate;
    logic        r_awready, r_wready, r_bvalid, r_aw_done, r_w_done;
    logic [2:0]  r_waddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_arready, r_rvalid;
    logic [31:0] r_rdata;
    logic        r_irq_en, r_done, r_start, r_irq;
    logic [31:0] r_dim, r_a_base, r_b_base, r_c_base, r_scratch;

    logic        w_commit, w_irq_en_next, w_done_next;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    // Address LSBs and protection bits carry no meaning for this block
    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Commit happens one edge after both address and data are held
    assign w_commit = (r_wstate == W_IDLE) && r_aw_done && r_w_done;

    // Write FSM: capture AW and W independently, then commit and respond
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_waddr   <= 3'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (r_aw_done && r_w_done) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_wstate  <= W_RESP;
                    end else begin
                        if (s00_axi_awvalid && r_awready) begin
                            r_waddr   <= s00_axi_awaddr[4:2];
                            r_aw_done <= 1'b1;
                            r_awready <= 1'b0;
                        end
                        if (s00_axi_wvalid && r_wready) begin
                            r_wdata  <= s00_axi_wdata;
                            r_wstrb  <= s00_axi_wstrb;
                            r_w_done <= 1'b1;
                            r_wready <= 1'b0;
                        end
                    end
                end
                W_RESP: begin
                    if (s00_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Next value of the single-bit control/status flags; a done pulse beats a clear
    always_comb begin
        w_irq_en_next = r_irq_en;
        w_done_next   = r_done;
        if (w_commit && (r_waddr == REG_CTRL) && r_wstrb[0])
            w_irq_en_next = r_wdata[BIT_IRQ_EN];
        if (w_commit && (r_waddr == REG_STATUS) && r_wstrb[0] && r_wdata[BIT_DONE])
            w_done_next = 1'b0;
        if (done_i)
            w_done_next = 1'b1;
    end

    // Register file, start pulse and interrupt update
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_irq_en  <= RST_BIT;
            r_done    <= RST_BIT;
            r_start   <= 1'b0;
            r_irq     <= 1'b0;
            r_dim     <= RST_CFG;
            r_a_base  <= RST_CFG;
            r_b_base  <= RST_CFG;
            r_c_base  <= RST_CFG;
            r_scratch <= RST_CFG;
        end else begin
            r_irq_en <= w_irq_en_next;
            r_done   <= w_done_next;
            r_irq    <= w_done_next & w_irq_en_next;
            r_start  <= w_commit && (r_waddr == REG_CTRL) && r_wstrb[0]
                        && r_wdata[BIT_START] && !busy_i;
            if (w_commit) begin
                case (r_waddr)
                    REG_DIM:     r_dim     <= wstrb_merge(r_dim,     r_wdata, r_wstrb);
                    REG_A_BASE:  r_a_base  <= wstrb_merge(r_a_base,  r_wdata, r_wstrb);
                    REG_B_BASE:  r_b_base  <= wstrb_merge(r_b_base,  r_wdata, r_wstrb);
                    REG_C_BASE:  r_c_base  <= wstrb_merge(r_c_base,  r_wdata, r_wstrb);
                    REG_SCRATCH: r_scratch <= wstrb_merge(r_scratch, r_wdata, r_wstrb);
                    default: ;
                endcase
            end
        end
    end

    // Read data selection from current (pre-commit) register contents
    always_comb begin
        w_rd_mux = 32'd0;
        case (s00_axi_araddr[4:2])
            REG_CTRL:    w_rd_mux[BIT_IRQ_EN] = r_irq_en;
            REG_STATUS: begin
                w_rd_mux[BIT_BUSY] = busy_i;
                w_rd_mux[BIT_DONE] = r_done;
            end
            REG_DIM:     w_rd_mux = r_dim;
            REG_A_BASE:  w_rd_mux = r_a_base;
            REG_B_BASE:  w_rd_mux = r_b_base;
            REG_C_BASE:  w_rd_mux = r_c_base;
            REG_SCRATCH: w_rd_mux = r_scratch;
            REG_VERSION: w_rd_mux = VERSION;
            default:     w_rd_mux = 32'd0;
        endcase
    end

    // Read FSM: register data on AR handshake, hold it until R handshake
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s00_axi_arvalid) begin
                        r_rdata   <= w_rd_mux;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s00_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_wready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = RESP_OKAY;
    assign start_o         = r_start;
    assign irq_o           = r_irq;
    assign dim_o           = r_dim;
    assign a_base_o        = r_a_base;
    assign b_base_o        = r_b_base;
    assign c_base_o        = r_c_base;

endmodule

// File: tb/tb_matrix_multiplier_axil_slave.sv
// Bench for the matrix multiplier AXI4-Lite register bank.
module tb_matrix_multiplier_axil_slave;

    localparam logic [4:0] A_CTRL = 5'h00, A_STATUS = 5'h04, A_DIM = 5'h08,
                           A_SCRATCH = 5'h18, A_VERSION = 5'h1C;
    localparam int MAX_WAIT = 50;

    logic        clk = 1'b0;
    logic        areset;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        busy_i, done_i, start_o, irq_o;
    logic [31:0] dim_o, a_base_o, b_base_o, c_base_o;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[6];

    matrix_multiplier_axil_slave dut (
        .s00_axi_aclk(clk), .s00_axi_areset(areset),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .busy_i(busy_i), .done_i(done_i), .start_o(start_o),
        .dim_o(dim_o), .a_base_o(a_base_o), .b_base_o(b_base_o), .c_base_o(c_base_o),
        .irq_o(irq_o)
    );

    // Clock
    always #5 clk = ~clk;

    // Count start pulses away from the active edge
    always @(negedge clk) if (start_o) start_cnt++;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait until bvalid is seen (bounded), leave bready as set by caller
    task automatic wait_bvalid(input string name);
        int n = 0;
        while (!bvalid && n < MAX_WAIT) begin step(); n++; end
        check({name, "_bvalid_timeout"}, {31'd0, bvalid}, 32'd1);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic aw_pend = 1'b1, w_pend = 1'b1;
        logic aw_hs, w_hs;
        int n = 0;
        step();
        awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
        while ((aw_pend || w_pend) && n < MAX_WAIT) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) begin awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_hs)  begin wvalid  = 1'b0; w_pend  = 1'b0; end
            n++;
        end
        check("wr_accept_timeout", {31'd0, aw_pend | w_pend}, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        wait_bvalid("wr");
        check("bresp", {30'd0, bresp}, 32'd0);
        step();
        bready = 1'b0;
    endtask

    // Scoreboard read: expected value is queued when AR is driven
    task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] e;
        int n = 0;
        step();
        araddr = addr; arvalid = 1'b1;
        exp_q.push_back(exp);
        while (!arready && n < MAX_WAIT) begin step(); n++; end
        step();
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < MAX_WAIT) begin step(); n++; end
        check({name, "_rvalid_timeout"}, {31'd0, rvalid}, 32'd1);
        e = exp_q.pop_front();
        check(name, rdata, e);
        check({name, "_rresp"}, {30'd0, rresp}, 32'd0);
        step();
        rready = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        busy_i = 1'b0; done_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;

        // Reset state
        check("rst_awready", {31'd0, awready}, 32'd1);
        check("rst_wready",  {31'd0, wready},  32'd1);
        check("rst_arready", {31'd0, arready}, 32'd1);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check("rst_start",   {31'd0, start_o}, 32'd0);
        check("rst_irq",     {31'd0, irq_o},   32'd0);
        check("rst_dim",     dim_o, 32'd0);

        // Table: sequential writes then read-back
        tbl[0] = '{5'h08, 32'h0000_0001, 4'hF, 32'h0000_0001};
        tbl[1] = '{5'h0C, 32'h0000_0002, 4'hF, 32'h0000_0002};
        tbl[2] = '{5'h10, 32'h0000_0003, 4'hF, 32'h0000_0003};
        tbl[3] = '{5'h14, 32'h0000_0004, 4'hF, 32'h0000_0004};
        tbl[4] = '{5'h18, 32'h0000_0005, 4'hF, 32'h0000_0005};
        tbl[5] = '{5'h1C, 32'hDEAD_BEEF, 4'hF, 32'h0001_0000};
        for (int i = 0; i < 6; i++) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
        for (int i = 0; i < 6; i++) axi_read(tbl[i].addr, tbl[i].exp, $sformatf("tbl_rd%0d", i));
        check("out_dim",    dim_o,    32'd1);
        check("out_a_base", a_base_o, 32'd2);
        check("out_b_base", b_base_o, 32'd3);
        check("out_c_base", c_base_o, 32'd4);

        // W three cycles ahead of AW, single byte strobe
        axi_write(A_SCRATCH, 32'h0, 4'hF);
        step();
        wdata = 32'hAABB_CCDD; wstrb = 4'b0010; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        step(); step();
        check("early_w_wready", {31'd0, wready},  32'd0);
        check("early_w_awready", {31'd0, awready}, 32'd1);
        check("early_w_nobvalid", {31'd0, bvalid}, 32'd0);
        awaddr = A_SCRATCH; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        bready = 1'b1;
        wait_bvalid("early_w");
        step();
        bready = 1'b0;
        axi_read(A_SCRATCH, 32'h0000_CC00, "strb_scratch");

        // Backpressure: hold bready low with a second write queued
        step();
        awaddr = A_DIM; awvalid = 1'b1; wdata = 32'h11; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_bvalid("bp");
        awaddr = A_DIM; awvalid = 1'b1; wdata = 32'h22; wstrb = 4'hF; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid",  {31'd0, bvalid},  32'd1);
            check("bp_awready", {31'd0, awready}, 32'd0);
            check("bp_wready",  {31'd0, wready},  32'd0);
            step();
        end
        check("bp_dim_first", dim_o, 32'h11);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bp_bvalid_drop", {31'd0, bvalid}, 32'd0);
        check("bp_awready_back", {31'd0, awready}, 32'd1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        wait_bvalid("bp2");
        step();
        bready = 1'b0;
        axi_read(A_DIM, 32'h22, "bp_dim_second");

        // START with core idle, then busy
        start_cnt = 0;
        axi_write(A_CTRL, 32'h1, 4'hF);
        repeat (2) step();
        check("start_pulse_cnt", start_cnt, 32'd1);
        axi_read(A_CTRL, 32'h0, "ctrl_after_start");
        busy_i = 1'b1;
        start_cnt = 0;
        axi_write(A_CTRL, 32'h1, 4'hF);
        repeat (2) step();
        check("start_busy_cnt", start_cnt, 32'd0);
        axi_read(A_STATUS, 32'h1, "status_busy");
        busy_i = 1'b0;

        // DONE / IRQ
        axi_write(A_CTRL, 32'h2, 4'hF);
        axi_read(A_CTRL, 32'h2, "ctrl_irq_en");
        check("irq_before_done", {31'd0, irq_o}, 32'd0);
        step();
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check("irq_after_done", {31'd0, irq_o}, 32'd1);
        axi_read(A_STATUS, 32'h2, "status_done");

        // Clear colliding with a new done pulse: set wins
        step();
        awaddr = A_STATUS; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        done_i = 1'b1; bready = 1'b1;
        step();
        done_i = 1'b0;
        check("collide_bvalid", {31'd0, bvalid}, 32'd1);
        step();
        bready = 1'b0;
        check("collide_irq", {31'd0, irq_o}, 32'd1);
        axi_read(A_STATUS, 32'h2, "collide_status");

        // Plain clear
        axi_write(A_STATUS, 32'h2, 4'hF);
        check("clear_irq", {31'd0, irq_o}, 32'd0);
        axi_read(A_STATUS, 32'h0, "clear_status");

        // Reset while a write response is pending
        step();
        awaddr = A_DIM; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_bvalid("rst_mid");
        areset = 1'b1;
        step();
        areset = 1'b0;
        check("rst_mid_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_mid_dim_o", dim_o, 32'd0);
        axi_read(A_DIM, 32'h0, "rst_mid_dim");
        axi_read(A_VERSION, 32'h0001_0000, "rst_mid_version");

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
